// File: rtl/global_defs.sv
// Global sizing defaults shared across the MPU codebase.
package global_defs;

  // Matrix register address is MATRIX_REG_BITS+1 bits wide.
  localparam int MATRIX_REG_BITS   = 4;

  // Default number of store requesters sharing the store unit.
  localparam int STORE_ARB_REQS    = 4;

  // Default store watchdog limit, in clocks.
  localparam int STORE_ARB_TIMEOUT = 256;

endpackage

// File: rtl/mpu_data_types.sv
// Shared enumerated types for MPU control logic.
package mpu_data_types;

  // Store arbiter FSM states; encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ARB_IDLE       = 3'd0,
    ARB_ISSUE      = 3'd1,
    ARB_WAIT_START = 3'd2,
    ARB_WAIT_DONE  = 3'd3,
    ARB_RELEASE    = 3'd4
  } store_arb_state_e;

endpackage

// File: rtl/mpu_rr_arbiter.sv
// Combinational round-robin winner select. The search starts at rr_ptr_in
// and walks upward, wrapping at NUM_REQ; the first set request wins.
module mpu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [IDW-1:0]     rr_ptr_in,
  output logic               valid_out,
  output logic [IDW-1:0]     winner_out
);

  logic [IDW-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest set request is written last and wins.
  always_comb begin
    valid_out  = 1'b0;
    winner_out = '0;
    w_idx      = '0;
    for (int o = NUM_REQ - 1; o >= 0; o--) begin
      w_idx = IDW'((int'(rr_ptr_in) + o) % NUM_REQ);
      if (req_in[w_idx]) begin
        valid_out  = 1'b1;
        winner_out = w_idx;
      end
    end
  end

endmodule

// File: rtl/mpu_store_arbiter.sv
// Store arbiter: grants one of NUM_REQ requesters access to the shared
// store unit, round-robin, and reports completion per requester.
// Optional watchdog: define MPU_STORE_ARB_TIMEOUT_EN to abort a transfer
// whose store unit stays silent or busy for TIMEOUT_CYCLES clocks.
//
// Store unit handshake: store_req_out is a single-cycle request pulse
// (state ARB_ISSUE). The store unit answers by raising store_en_in for the
// duration of the element transfer; the first low cycle after it has been
// high marks the end of the transfer. store_addr_out is stable from the
// request pulse until the release cycle.
module mpu_store_arbiter
  import global_defs::*;
  import mpu_data_types::*;
#(
  parameter int NUM_REQ        = STORE_ARB_REQS,
  parameter int TIMEOUT_CYCLES = STORE_ARB_TIMEOUT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_in,
  input  logic [NUM_REQ*(MATRIX_REG_BITS+1)-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]                     grant_out,
  output logic [NUM_REQ-1:0]                     done_out,
  output logic [NUM_REQ-1:0]                     err_out,
  output logic                                   store_req_out,
  output logic [MATRIX_REG_BITS:0]               store_addr_out,
  input  logic                                   store_en_in,
  output logic [2:0]                             dbg_state_out
);

  localparam int AW  = MATRIX_REG_BITS + 1;
  localparam int IDW = $clog2(NUM_REQ);

  store_arb_state_e r_state;
  store_arb_state_e w_next_state;
  logic [IDW-1:0]     r_id;
  logic [IDW-1:0]     r_rr_ptr;
  logic [AW-1:0]      r_addr;

  logic               w_valid;
  logic [IDW-1:0]     w_winner;
  logic [IDW-1:0]     w_id_inc;
  logic [NUM_REQ-1:0] w_id_onehot;
  logic               w_timeout;
  logic               w_waiting;

  mpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req_in     (req_in),
    .rr_ptr_in  (r_rr_ptr),
    .valid_out  (w_valid),
    .winner_out (w_winner)
  );

  assign w_waiting   = (r_state == ARB_WAIT_START) || (r_state == ARB_WAIT_DONE);
  assign w_id_inc    = (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + IDW'(1);
  assign w_id_onehot = NUM_REQ'(1) << r_id;

`ifdef MPU_STORE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;

  // Watchdog: cleared while issuing, counts every cycle spent waiting on the store unit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ARB_ISSUE) begin
      r_cnt <= '0;
    end else if (w_waiting) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // The last counted wait cycle is the one that reaches the limit.
  assign w_timeout = w_waiting && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; the watchdog overrides the store unit in both wait states.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:       if (w_valid) w_next_state = ARB_ISSUE;
      ARB_ISSUE:      w_next_state = ARB_WAIT_START;
      ARB_WAIT_START: begin
        if (w_timeout)        w_next_state = ARB_IDLE;
        else if (store_en_in) w_next_state = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE:  begin
        if (w_timeout)         w_next_state = ARB_IDLE;
        else if (!store_en_in) w_next_state = ARB_RELEASE;
      end
      ARB_RELEASE:    w_next_state = ARB_IDLE;
      default:        w_next_state = ARB_IDLE;
    endcase
  end

  // Winner id/address latch and round-robin pointer advance after each finished or aborted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id     <= '0;
      r_addr   <= '0;
      r_rr_ptr <= '0;
    end else begin
      if ((r_state == ARB_IDLE) && w_valid) begin
        r_id   <= w_winner;
        r_addr <= req_addr_in[int'(w_winner)*AW +: AW];
      end
      if ((r_state == ARB_RELEASE) || w_timeout) begin
        r_rr_ptr <= w_id_inc;
      end
    end
  end

  // Outputs are decoded from state; the address register simply holds between transfers.
  always_comb begin
    grant_out     = '0;
    done_out      = '0;
    err_out       = '0;
    store_req_out = 1'b0;
    if (r_state != ARB_IDLE) grant_out = w_id_onehot;
    if (r_state == ARB_ISSUE) store_req_out = 1'b1;
    if (r_state == ARB_RELEASE) done_out = w_id_onehot;
`ifdef MPU_STORE_ARB_TIMEOUT_EN
    if (w_timeout) err_out = w_id_onehot;
`endif
  end

  assign store_addr_out = r_addr;
  assign dbg_state_out  = r_state;

endmodule

// File: doc/mpu_store_arbiter.md
MPU_STORE_ARBITER -- requirements
Module: mpu_store_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of store requesters, range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256: watchdog limit in clocks; used only when MPU_STORE_ARB_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1: clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_in, input, NUM_REQ: per-requester store request, level.
REQ-006 SHALL have port req_addr_in, input, NUM_REQ x (MATRIX_REG_BITS+1): per-requester source matrix register address.
REQ-007 SHALL have port grant_out, output, NUM_REQ: one-hot grant.
REQ-008 SHALL have port done_out, output, NUM_REQ: one-cycle completion pulse per requester.
REQ-009 SHALL have port err_out, output, NUM_REQ: one-cycle timeout pulse per requester.
REQ-010 SHALL have port store_req_out, input side of store unit, output, 1: store request to the store unit.
REQ-011 SHALL have port store_addr_out, output, MATRIX_REG_BITS+1: matrix address to the store unit.
REQ-012 SHALL have port store_en_in, input, 1: the store unit's memory store enable; high while elements transfer.

Function
REQ-013 SHALL implement states ARB_IDLE, ARB_ISSUE, ARB_WAIT_START, ARB_WAIT_DONE, ARB_RELEASE.
REQ-014 ARB_IDLE: if any req_in bit is set, SHALL select the winner round-robin from rr_ptr upward (wrapping), latch the winner id and its req_addr_in, and go to ARB_ISSUE; otherwise stay.
REQ-015 ARB_ISSUE: SHALL drive store_req_out=1 for exactly one cycle, then go to ARB_WAIT_START.
REQ-016 ARB_WAIT_START: SHALL go to ARB_WAIT_DONE on the first cycle store_en_in=1.
REQ-017 ARB_WAIT_DONE: SHALL go to ARB_RELEASE on the first cycle store_en_in=0.
REQ-018 ARB_RELEASE: SHALL pulse done_out[id] for one cycle, set rr_ptr to id+1 mod NUM_REQ, and return to ARB_IDLE.
REQ-019 grant_out[id] SHALL be high from ARB_ISSUE through ARB_RELEASE inclusive, and zero in ARB_IDLE.
REQ-020 store_addr_out SHALL hold the latched address from ARB_ISSUE through ARB_RELEASE, and hold its last value otherwise.
REQ-021 Latency: a request sampled in ARB_IDLE at cycle N SHALL produce store_req_out at cycle N+1.
REQ-022 Deassertion of req_in[id] mid-transfer SHALL be ignored; the transfer completes and done_out still pulses.
REQ-023 Changes to req_addr_in after latching SHALL be ignored.
REQ-024 A requester still asserting req_in after done SHALL be eligible again only per the round-robin order, with no back-to-back starvation of others.
REQ-025 With a single active requester, minimum turnaround SHALL be ARB_RELEASE then ARB_IDLE, then re-grant.

Reset
REQ-026 On rst: state=ARB_IDLE, rr_ptr=0, latched id=0, latched address=0; grant_out, done_out, err_out, store_req_out=0; store_addr_out=0.
REQ-027 rst asserted mid-transfer SHALL abort without a done_out pulse; on the next cycle all outputs are at reset values.

Configuration
REQ-028 With macro MPU_STORE_ARB_TIMEOUT_EN defined: a counter SHALL clear on ARB_ISSUE and increment in ARB_WAIT_START/ARB_WAIT_DONE.
REQ-029 When that counter reaches TIMEOUT_CYCLES, the block SHALL pulse err_out[id] (not done_out), advance rr_ptr, and return to ARB_IDLE.
REQ-030 Without MPU_STORE_ARB_TIMEOUT_EN: no counter, err_out tied 0, and the wait states SHALL wait indefinitely.

Structure
REQ-031 store_arb_state_e SHALL reside in mpu_data_types.
REQ-032 STORE_ARB_REQS and STORE_ARB_TIMEOUT defaults SHALL reside in global_defs.
REQ-033 Round-robin winner selection SHALL be a combinational sub-module mpu_rr_arbiter (inputs req, rr_ptr; outputs valid, winner id).

Verification
REQ-034 Single request: req_in=4'b0010, addr[1]=5 -> store_req_out pulse next cycle, store_addr_out=5, grant_out=4'b0010; store_en 6 cycles -> done_out=4'b0010 one cycle after store_en falls.
REQ-035 Contention: req_in=4'b1111 held, rr_ptr=0 -> grants in order 0,1,2,3,0, one complete transfer each.
REQ-036 Drop mid-transfer: req_in[2] falls during ARB_WAIT_DONE -> transfer completes, done_out[2] pulses.
REQ-037 Reset mid-transfer: rst in ARB_WAIT_DONE -> all outputs 0 next cycle, no done pulse, rr_ptr=0.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=16): store_en_in never rises -> err_out[id] pulses 16 cycles after ARB_ISSUE, then next requester is granted.
REQ-039 Late start: store_en_in rises 3 cycles after store_req_out -> stays in ARB_WAIT_START for 3 cycles, then completes normally.
